// File: rtl/adaptive_filter_mode_ctrl.sv
// adaptive_filter_mode_ctrl: mode sequencer for adaptive_filter (drain, flush, switch); output blanking enabled by ADAPTIVE_FILTER_MODE_CTRL_BLANK_EN
module adaptive_filter_mode_ctrl #(
  parameter int FLUSH_LEN = 2,
  parameter int WARMUP = 6,
  parameter bit INIT_MODE = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             mode_req,
  input  logic             mode_req_valid,
  output logic             mode_req_ready,
  input  logic [7:-6]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [7:-6]      f_tdata,
  output logic             f_tvalid,
  output logic             f_ctrl,
  output logic             f_srst,
  input  logic [7:-6]      f_m_tdata,
  input  logic             f_m_tvalid,
  output logic [7:-6]      m_tdata,
  output logic             m_tvalid,
  output logic             cur_mode,
  output logic             switch_done,
  output logic [CNT_W-1:0] sample_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
  state_t state, state_nxt;
  logic mode, pend, done, req_acc;
  logic [3:0] flush_cnt;
  logic [CNT_W-1:0] cnt;
  assign s_tready = (state == RUN) & ~srst;
  assign mode_req_ready = s_tready;
  assign req_acc = mode_req_valid & mode_req_ready;
  assign f_tdata = s_tdata;
  assign f_tvalid = s_tvalid & s_tready;
  assign f_ctrl = mode;
  assign cur_mode = mode;
  assign f_srst = srst | (state == FLUSH);
  assign m_tdata = f_m_tdata;
  assign switch_done = done;
  assign sample_cnt = cnt;
  // next state: a differing request starts the drain, drain is one cycle, flush runs until its counter expires
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN) ? ((req_acc && mode_req != mode) ? DRAIN : RUN)
              : (state == DRAIN) ? FLUSH
              : (flush_cnt == 4'd0) ? RUN : FLUSH;
  end
  // state, mode switch on flush entry, flush countdown and completion pulse
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= RUN;
      mode <= INIT_MODE;
      pend <= INIT_MODE;
      flush_cnt <= 4'd0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && req_acc) pend <= mode_req;
      if (state == DRAIN) begin
        mode <= pend;
        flush_cnt <= 4'(FLUSH_LEN - 1);
      end else if (state == FLUSH && flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
      done <= (state == FLUSH) && (flush_cnt == 4'd0);
    end
  end
  // saturating count of accepted samples, cleared by a flush
  always_ff @(posedge clk) begin
    if (srst || state == FLUSH) cnt <= '0;
    else if (f_tvalid && !(&cnt)) cnt <= cnt + 1'b1;
  end
`ifdef ADAPTIVE_FILTER_MODE_CTRL_BLANK_EN
  logic [3:0] blank_cnt;
  // reload during flush so the first filter outputs after a switch are suppressed
  always_ff @(posedge clk) begin
    if (srst) blank_cnt <= 4'd0;
    else if (state == FLUSH) blank_cnt <= 4'(WARMUP);
    else if (f_m_tvalid && blank_cnt != 4'd0) blank_cnt <= blank_cnt - 4'd1;
  end
  assign m_tvalid = f_m_tvalid & (blank_cnt == 4'd0);
`else
  assign m_tvalid = f_m_tvalid;
`endif
endmodule
